// File: rtl/pipe_pkg.sv
// Shared pipeline-stage payload types, widths and reset defaults.
package pipe_pkg;

    localparam int unsigned OCC_W  = 2;
    localparam int unsigned PERF_W = 32;

    typedef struct packed {
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic [23:0] mem_addr;
        logic        rd_e;
        logic [1:0]  length;
    } ex_mem_payload_t;

    localparam int unsigned     EX_MEM_DATA_W     = $bits(ex_mem_payload_t);
    localparam ex_mem_payload_t EX_MEM_RESET_DATA = '0;

    typedef struct packed {
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic        rd_e;
    } mem_wb_payload_t;

    localparam int unsigned     MEM_WB_DATA_W     = $bits(mem_wb_payload_t);
    localparam mem_wb_payload_t MEM_WB_RESET_DATA = '0;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// Single valid+data register with enable, clear, valid-write and data-write controls.
module pipe_stage_reg_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = EX_MEM_DATA_W,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clear,
    input  logic              i_wr_valid,
    input  logic              i_valid,
    input  logic              i_wr_data,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Clear wins over writes; data is only rewritten on an explicit data write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_en) begin
            if (i_clear) begin
                r_valid <= 1'b0;
                r_data  <= RESET_DATA;
            end else begin
                if (i_wr_valid) r_valid <= i_valid;
                if (i_wr_data)  r_data  <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and global freeze.
// Optional PIPE_STAGE_PERF_EN adds stall/bubble performance counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = EX_MEM_DATA_W,
    parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(EX_MEM_RESET_DATA)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_bubble_cnt
`endif
);

    logic              w_main_valid, w_skid_valid;
    logic [DATA_W-1:0] w_main_data, w_skid_data;
    logic              w_in_ready, w_out_valid, w_in_fire, w_out_fire;

    logic              w_main_wr_valid, w_main_valid_d, w_main_wr_data;
    logic [DATA_W-1:0] w_main_d;
    logic              w_skid_wr_valid, w_skid_valid_d, w_skid_wr_data;

    // in_ready depends only on registered state, never on out_ready.
    assign w_in_ready  = rdy & ~w_skid_valid & rst_n;
    assign w_out_valid = rdy & w_main_valid;
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    always_comb begin
        w_main_wr_valid = 1'b0;
        w_main_valid_d  = 1'b0;
        w_main_wr_data  = 1'b0;
        w_main_d        = in_data;
        w_skid_wr_valid = 1'b0;
        w_skid_valid_d  = 1'b0;
        w_skid_wr_data  = 1'b0;
        if (w_out_fire) begin
            w_main_wr_valid = 1'b1;
            if (w_skid_valid) begin
                w_main_valid_d  = 1'b1;
                w_main_wr_data  = 1'b1;
                w_main_d        = w_skid_data;
                w_skid_wr_valid = 1'b1;
            end else begin
                w_main_valid_d = w_in_fire;
                w_main_wr_data = w_in_fire;
            end
        end else if (w_in_fire) begin
            if (w_main_valid) begin
                w_skid_wr_valid = 1'b1;
                w_skid_valid_d  = 1'b1;
                w_skid_wr_data  = 1'b1;
            end else begin
                w_main_wr_valid = 1'b1;
                w_main_valid_d  = 1'b1;
                w_main_wr_data  = 1'b1;
            end
        end
    end

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (rdy),
        .i_clear    (flush),
        .i_wr_valid (w_main_wr_valid),
        .i_valid    (w_main_valid_d),
        .i_wr_data  (w_main_wr_data),
        .i_data     (w_main_d),
        .o_valid    (w_main_valid),
        .o_data     (w_main_data)
    );

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (rdy),
        .i_clear    (flush),
        .i_wr_valid (w_skid_wr_valid),
        .i_valid    (w_skid_valid_d),
        .i_wr_data  (w_skid_wr_data),
        .i_data     (in_data),
        .o_valid    (w_skid_valid),
        .o_data     (w_skid_data)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_main_data;
    assign occupancy = OCC_W'(w_main_valid) + OCC_W'(w_skid_valid);

`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt, r_bubble_cnt;

    // Free-running wrap-around counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (rdy) begin
            if (w_out_valid & ~out_ready) r_stall_cnt  <= r_stall_cnt + PERF_W'(1);
            if (~w_out_valid & out_ready) r_bubble_cnt <= r_bubble_cnt + PERF_W'(1);
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule
